filtro_lector_resultados: RTL and testbench
===========================================

Name: filtro_lector_resultados

Overview:
Reader side of the filter result memory. The filter FSM writes its computed words into the result RAM. This block reads them back in order after a start command and streams them out over a valid/ready handshake toward the CPU data path or an output port. It also publishes a status word that the CPU polls through the control/status register map.

Parameters:
DATA_W, 32, width of one result word and of out_data
ADDR_W, 4, result RAM address width
N_WORDS, 9, number of result words read per transfer (1..2^ADDR_W)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (block is in reset while reset==0)
start  in  1  single-cycle command pulse decoded from CPU control register bit 0
base_addr  in  ADDR_W  first RAM address, sampled on accepted start
rd_en  out  1  RAM read strobe
rd_addr  out  ADDR_W  RAM read address
rd_data  in  DATA_W  RAM read data, valid exactly 1 cycle after rd_en
out_data  out  DATA_W  streamed result word
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts word when out_valid && out_ready
busy  out  1  transfer in progress
done  out  1  one-cycle pulse after the last word is accepted
status  out  32  {busy, done_sticky, 22'b0, count[7:0]}

Behaviour:
- Reset: state=IDLE. rd_en=0, rd_addr=0, out_data=0, out_valid=0, busy=0, done=0, count=0, done_sticky=0.
- States: IDLE, READ, CAPTURE, SEND, FIN.
- IDLE: start=1 -> latch addr<=base_addr, count<=0, clear done_sticky, busy<=1, go to READ. start in any other state is ignored, with no queuing.
- READ: rd_en=1 and rd_addr=addr for exactly one cycle -> CAPTURE.
- CAPTURE: out_data<=rd_data, out_valid<=1 -> SEND.
- SEND: hold out_data and out_valid stable until out_ready=1. On handshake: count+1, addr+1 (wraps modulo 2^ADDR_W), out_valid<=0. If count+1==N_WORDS go to FIN, else go to READ.
- FIN: done=1 for one cycle, done_sticky<=1, busy<=0 -> IDLE.
- Minimum 3 cycles per word. out_ready held low stalls indefinitely with no timeout.
- out_ready is ignored while out_valid=0.
- If reset drops mid-transfer, all outputs return to reset values immediately. The partial transfer is lost and not resumed.
- count is 8 bits. status[7:0]=count, status[30]=done_sticky, status[31]=busy.
- rd_en is never asserted outside READ.

Optional Feature:
FILTRO_LECTOR_CLEAR_EN
- Defined: adds outputs clr_we (1) and clr_addr (ADDR_W). In the cycle of each SEND handshake, clr_we=1 and clr_addr=address just sent, so the RAM slot is zeroed. Reset value of clr_we is 0.
- Undefined: ports and logic are absent, and RAM contents are untouched.

Decomposition:
- Package filtro_pkg: state enum lector_state_t (3-bit, IDLE=0..FIN=4), status bit-position constants (STAT_BUSY=31, STAT_DONE=30), control bit index CTRL_START=0.
- No sub-module. A single FSM plus datapath registers is sufficient.

Test Plan:
- Basic: reset released, RAM[0..8]=10..18, base_addr=0, start pulse, out_ready=1 -> 9 words 10..18 in order, done pulse one cycle after the 9th handshake, status=0x4000_0009.
- Backpressure: out_ready low for 5 cycles during word 3 -> out_data=12 and out_valid held stable throughout, no rd_en issued, transfer completes with 9 words.
- Wrap: base_addr=12, ADDR_W=4 -> reads addresses 12,13,14,15,0,1,2,3,4 in that order.
- Start while busy: second start pulse during word 4 -> ignored, exactly 9 words, single done pulse.
- Reset mid-transfer: reset=0 while in SEND of word 5 -> out_valid=0, busy=0, status=0 immediately. A new start reads again from base_addr.
- Clear (FILTRO_LECTOR_CLEAR_EN): basic run -> clr_we pulses 9 times with clr_addr 0..8, each coincident with a handshake.

Source files
------------

// File: rtl/filtro_lector_resultados_pkg.sv
// Shared types and constants for the filter result reader: FSM state encoding
// and the bit positions used in the CPU control/status register map.
package filtro_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        CAPTURE = 3'd2,
        SEND    = 3'd3,
        FIN     = 3'd4
    } lector_state_t;

    localparam int STAT_BUSY  = 31;
    localparam int STAT_DONE  = 30;
    localparam int CTRL_START = 0;
    localparam int COUNT_W    = 8;

endpackage

// File: rtl/filtro_lector_resultados.sv
// Reads N_WORDS result words from the result RAM starting at base_addr and streams
// them out over valid/ready. Optional macro FILTRO_LECTOR_CLEAR_EN zeroes each slot once sent.
module filtro_lector_resultados
    import filtro_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 4,
    parameter int N_WORDS = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [31:0]       status,
`ifdef FILTRO_LECTOR_CLEAR_EN
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
`endif
    output logic [2:0]        dbg_state
);

    // Handshake: a word transfers on a rising edge where out_valid && out_ready.
    // out_valid/out_data never change while out_valid=1 and out_ready=0.

    lector_state_t       state, next_state;
    logic [ADDR_W-1:0]   addr;
    logic [COUNT_W-1:0]  count;
    logic                done_sticky;
    logic                last_word;

    // out_valid is 1 throughout SEND, so out_ready alone qualifies the handshake.
    assign last_word = (count == COUNT_W'(N_WORDS - 1));
    assign rd_addr   = addr;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        rd_en      = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE:    if (start) next_state = READ;
            READ: begin
                rd_en      = 1'b1;
                next_state = CAPTURE;
            end
            CAPTURE: next_state = SEND;
            SEND:    if (out_ready) next_state = last_word ? FIN : READ;
            FIN: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr        <= '0;
            count       <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            done_sticky <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        addr        <= base_addr;
                        count       <= '0;
                        done_sticky <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                CAPTURE: begin
                    out_data  <= rd_data;
                    out_valid <= 1'b1;
                end
                SEND: begin
                    if (out_ready) begin
                        count     <= count + COUNT_W'(1);
                        addr      <= addr + ADDR_W'(1);
                        out_valid <= 1'b0;
                    end
                end
                FIN: begin
                    done_sticky <= 1'b1;
                    busy        <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        status                = '0;
        status[STAT_BUSY]     = busy;
        status[STAT_DONE]     = done_sticky;
        status[COUNT_W-1:0]   = count;
    end

`ifdef FILTRO_LECTOR_CLEAR_EN
    // Addr still points at the word being sent until the handshake edge.
    assign clr_we   = (state == SEND) && out_ready;
    assign clr_addr = addr;
`endif

endmodule

// File: tb/tb_filtro_lector_resultados.sv
// Bench for filtro_lector_resultados: RAM model, directed transfers with random data
// and backpressure, checked against a queue of words derived from base address order.
module tb_filtro_lector_resultados;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 4;
    localparam int N_WORDS = 9;
    localparam int DEPTH   = 1 << ADDR_W;

    logic              clk;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;
    logic [31:0]       status;
`ifdef FILTRO_LECTOR_CLEAR_EN
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
`endif
    logic [2:0]        dbg_state;

    filtro_lector_resultados #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .N_WORDS(N_WORDS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .base_addr(base_addr),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy),
        .done     (done),
        .status   (status),
`ifdef FILTRO_LECTOR_CLEAR_EN
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
`endif
        .dbg_state(dbg_state)
    );

    // Clock and RAM model: read data appears one cycle after rd_en.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [DATA_W-1:0] ram [DEPTH];

    initial rd_data = '0;
    always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_assert = 0;
    int n_fail   = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] addr_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < DEPTH; i++) ram[i] = $urandom;
    endtask

    // One transfer from base. stall_word: word index held off for 5 cycles.
    // restart_word: pulse start while that word is offered. abort_word: drop reset there.
    task automatic run_xfer(input logic [ADDR_W-1:0] base, input int stall_word,
                            input bit rand_stall, input int restart_word, input int abort_word);
        int                words, cycles, stall_cnt, dones;
        bit                restarted;
        logic              prev_v, prev_r, rdy;
        logic [DATA_W-1:0] prev_d;
        logic [ADDR_W-1:0] sent_addr;

        exp_q.delete();
        addr_q.delete();
        for (int i = 0; i < N_WORDS; i++) begin
            exp_q.push_back(ram[(int'(base) + i) % DEPTH]);
            addr_q.push_back(ADDR_W'((int'(base) + i) % DEPTH));
        end

        @(negedge clk);
        base_addr = base;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        chk("status_at_start", status, 32'h8000_0000);

        words = 0; cycles = 0; stall_cnt = 0; dones = 0; restarted = 0;
        prev_v = 1'b0; prev_r = 1'b0; prev_d = '0;
        while (words < N_WORDS && cycles < 400) begin
            if (rd_en) begin
                chk("rd_addr", 32'(rd_addr), 32'(addr_q.pop_front()));
                chk("rd_en_while_valid", 32'(out_valid), 32'd0);
            end
            if (prev_v && !prev_r) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", out_data, prev_d);
            end
            if (done) dones++;

            if (out_valid && words == abort_word) begin
                reset = 1'b0;
                #1;
                chk("abort_valid", 32'(out_valid), 32'd0);
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_status", status, 32'd0);
                chk("abort_data", out_data, 32'd0);
                chk("abort_rd_en", 32'(rd_en), 32'd0);
                out_ready = 1'b0;
                @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                return;
            end

            if (out_valid && words == restart_word && !restarted) begin
                start     = 1'b1;
                base_addr = base + ADDR_W'(5);
                restarted = 1'b1;
            end else begin
                start = 1'b0;
            end

            if (out_valid) begin
                if (words == stall_word && stall_cnt < 5) begin
                    rdy = 1'b0;
                    stall_cnt++;
                end else if (rand_stall) begin
                    rdy = ($urandom_range(0, 3) != 0);
                end else begin
                    rdy = 1'b1;
                end
            end else begin
                rdy = 1'($urandom_range(0, 1));
            end
            out_ready = rdy;
            #1;
            sent_addr = ADDR_W'((int'(base) + words) % DEPTH);
`ifdef FILTRO_LECTOR_CLEAR_EN
            chk("clr_we", 32'(clr_we), 32'(out_valid && out_ready));
            if (out_valid && out_ready) chk("clr_addr", 32'(clr_addr), 32'(sent_addr));
`endif
            if (out_valid && out_ready) begin
                chk("word", out_data, exp_q.pop_front());
                words++;
            end
            prev_v = out_valid;
            prev_r = out_ready;
            prev_d = out_data;
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;

        chk("word_count", 32'(words), N_WORDS);
        chk("done_early", 32'(dones), 32'd0);
        chk("fin_done", 32'(done), 32'd1);
        chk("fin_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("post_done", 32'(done), 32'd0);
        chk("post_status", status, 32'h4000_0000 | 32'(N_WORDS));
        for (int i = 0; i < 3; i++) begin
            chk("idle_quiet", {29'd0, rd_en, done, busy}, 32'd0);
            @(negedge clk);
        end
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) ram[i] = DATA_W'(10 + i);

        repeat (2) @(negedge clk);
        chk("rst_rd_en", 32'(rd_en), 32'd0);
        chk("rst_rd_addr", 32'(rd_addr), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_status", status, 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Basic: words 10..18 from address 0
        run_xfer(4'd0, -1, 1'b0, -1, -1);
        // Backpressure on the third word (value 12)
        run_xfer(4'd0, 2, 1'b0, -1, -1);

        fill_random();
        // Address wrap from 12 through 4
        run_xfer(4'd12, -1, 1'b0, -1, -1);
        // Start pulse while busy is ignored
        run_xfer(4'($urandom_range(0, DEPTH - 1)), -1, 1'b0, 3, -1);
        // Reset during the fifth word, then a fresh run from the same base
        run_xfer(4'd6, -1, 1'b0, -1, 4);
        run_xfer(4'd6, -1, 1'b1, -1, -1);

        for (int t = 0; t < 6; t++) begin
            fill_random();
            run_xfer(4'($urandom_range(0, DEPTH - 1)),
                     int'($urandom_range(0, N_WORDS - 1)), 1'b1, -1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
